mem_stage_axi: RTL and testbench
================================

Name: mem_stage_axi

Overview:
- Memory stage of the RV32IM pipeline with an AXI4-Lite master port replacing the local data memory.
- Converts LB/LH/LW/LBU/LHU/SB/SH/SW into single AXI4-Lite transactions, steering bytes by lane.
- Stalls the pipeline until each transaction completes; presents the load result as a stable registered value to MEM/WB.
- Adds misalignment detection and bus-error reporting.

Parameters:
- ADDR_WIDTH, 32, AXI address width; low bits of result are used, aligned down to a word.
- AXI_PROT, 3'b000, constant driven on awprot/arprot.
- ALIGN_CHECK, 1, 1 = misaligned accesses are suppressed and flagged; 0 = issued with the word-aligned address and lane strobes.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- result  in  32  ALU result / effective address.
- op2_data  in  32  store data.
- mem_read  in  1  load in stage.
- mem_write  in  1  store in stage.
- store_type  in  2  00 SB, 01 SH, 10 SW.
- load_type  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- read_data  out  32  extended load data, registered.
- calculated_result  out  32  passthrough of result.
- mem_stall  out  1  freeze upstream pipeline.
- misalign  out  1  one-cycle pulse.
- bus_error  out  1  one-cycle pulse on non-OKAY response.
- AXI write address: m_awaddr out ADDR_WIDTH, m_awprot out 3, m_awvalid out 1, m_awready in 1.
- AXI write data: m_wdata out 32, m_wstrb out 4, m_wvalid out 1, m_wready in 1.
- AXI write response: m_bresp in 2, m_bvalid in 1, m_bready out 1.
- AXI read address: m_araddr out ADDR_WIDTH, m_arprot out 3, m_arvalid out 1, m_arready in 1.
- AXI read data: m_rdata in 32, m_rresp in 2, m_rvalid in 1, m_rready out 1.

Behaviour:
- Reset (rst=0, async): state IDLE; all valid/ready outputs 0; read_data 0; misalign 0; bus_error 0; address/data/strobe registers 0.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE:
  - mem_write -> latch addr, wdata, wstrb; go WR_REQ.
  - mem_read -> latch addr, load_type; go RD_REQ.
  - Both asserted: write wins.
  - Misaligned (SH/LH/LHU with addr[0]=1; SW/LW with addr[1:0]!=0) and ALIGN_CHECK=1: no transaction, misalign=1 for one cycle, stay IDLE, no stall.
- WR_REQ:
  - awvalid and wvalid rise together; each drops independently on its own handshake.
  - Leave to WR_RESP once both have handshaked, whether in the same or different cycles.
- WR_RESP: bready=1; on bvalid go DONE; bresp!=00 -> bus_error pulse in DONE.
- RD_REQ: arvalid=1 until arready, then go RD_RESP.
- RD_RESP:
  - rready=1; on rvalid capture the lane-extracted, sign/zero-extended rdata into read_data and go DONE.
  - rresp!=00 -> read_data=0 and bus_error pulse.
- DONE: stall low for exactly one cycle (pipeline advances); next state IDLE.
- AXI protocol: a valid, once high, never drops before its ready; no timeout, no abort.
- mem_stall = (IDLE & (mem_read|mem_write) & ~misalign_cond) | state in {WR_REQ, WR_RESP, RD_REQ, RD_RESP}.
- Address: m_awaddr/m_araddr = {result[ADDR_WIDTH-1:2], 2'b00}.
- Store lane steering:
  - SB: wdata = byte replicated x4, wstrb = 4'b0001 << addr[1:0].
  - SH: wdata = half replicated x2, wstrb = 4'b0011 << addr[1:0].
  - SW: wdata = op2_data, wstrb = 4'b1111.
- Load extraction: byte = rdata >> (8*addr[1:0]); half = rdata >> (8*addr[1:0]) with addr[1] selecting the half; LB/LH sign-extend, LBU/LHU zero-extend.
- read_data holds its value until the next completed load.
- Minimum latency against a zero-wait slave: access issued in IDLE at cycle 0, valids at cycle 1, response at cycle 2, DONE at cycle 3. mem_stall is high cycles 0-2.
- Mid-transaction reset: immediate return to IDLE with all valids low. The slave is assumed to be reset by the same rst.

Decomposition:
- Shared package mem_axi_pkg holds:
  - LOAD_* / STORE_* encodings.
  - AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR.
  - FSM state localparams.
- One combinational sub-module, lsu_lane_align: wdata/wstrb generation, load extraction/extension, misalignment detect.

Test Plan:
- SW result=0x100, op2=0xDEADBEEF, zero-wait slave -> awaddr=0x100, wstrb=1111, wdata=0xDEADBEEF; stall high 3 cycles; bus_error=0.
- SB result=0x103, op2=0x000000A5 -> wstrb=1000, wdata=0xA5A5A5A5; awaddr=0x100.
- LB/LBU/LH result=0x102, slave rdata=0x80F07F11 -> LB gives 0xFFFFFFF0; LBU gives 0x000000F0; LH gives 0xFFFF80F0.
- Slave delays awready 2 cycles and wready 5 cycles, rvalid 4 cycles late -> valids stay high until their handshakes; stall extends accordingly; single DONE cycle.
- LW result=0x101, ALIGN_CHECK=1 -> no arvalid, misalign pulse, no stall. rresp=SLVERR on LW 0x200 -> read_data=0, bus_error pulse.
- rst deasserted-then-asserted low while in WR_REQ -> awvalid/wvalid low same cycle, read_data=0, state IDLE.

Source files
------------

// File: rtl/mem_axi_pkg.sv
// mem_axi_pkg: encodings and FSM states shared by the AXI4-Lite memory stage
package mem_axi_pkg;

    localparam logic [1:0] STORE_SB = 2'b00;
    localparam logic [1:0] STORE_SH = 2'b01;
    localparam logic [1:0] STORE_SW = 2'b10;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_DONE
    } state_e;

    // Anything other than OKAY (EXOKAY included) is treated as a failed access
    function automatic logic resp_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: store lane steering, load extraction/extension and misalignment detect
module lsu_lane_align
    import mem_axi_pkg::*;
#(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  store_type,
    input  logic [2:0]  load_type,
    input  logic [31:0] store_data,
    input  logic [1:0]  ld_addr_lo,
    input  logic [2:0]  ld_type,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] ld_data,
    output logic        misalign
);

    logic [31:0] shifted;
    logic        st_mis;
    logic        ld_mis;

    // Replicate store data across lanes, shift the read word down to the addressed lane and extend it
    always_comb begin
        wdata   = store_type == STORE_SB ? {4{store_data[7:0]}} :
                  store_type == STORE_SH ? {2{store_data[15:0]}} : store_data;
        wstrb   = store_type == STORE_SB ? 4'b0001 << addr_lo :
                  store_type == STORE_SH ? 4'b0011 << addr_lo : 4'b1111;
        shifted = rdata >> {ld_addr_lo, 3'b000};
        case (ld_type)
            LOAD_LB:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
            LOAD_LH:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
            LOAD_LBU: ld_data = {24'h0, shifted[7:0]};
            LOAD_LHU: ld_data = {16'h0, shifted[15:0]};
            default:  ld_data = rdata;
        endcase
        st_mis   = store_type == STORE_SH ? addr_lo[0] :
                   store_type == STORE_SW ? |addr_lo : 1'b0;
        ld_mis   = (load_type == LOAD_LH || load_type == LOAD_LHU) ? addr_lo[0] :
                   load_type == LOAD_LW ? |addr_lo : 1'b0;
        misalign = ALIGN_CHECK && (mem_write ? st_mis : (mem_read && ld_mis));
    end

endmodule

// File: rtl/mem_stage_axi.sv
// mem_stage_axi: pipeline memory stage issuing single AXI4-Lite transactions per load/store
module mem_stage_axi
    import mem_axi_pkg::*;
#(
    parameter int         ADDR_WIDTH  = 32,
    parameter logic [2:0] AXI_PROT    = 3'b000,
    parameter bit         ALIGN_CHECK = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           result,
    input  logic [31:0]           op2_data,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [1:0]            store_type,
    input  logic [2:0]            load_type,
    output logic [31:0]           read_data,
    output logic [31:0]           calculated_result,
    output logic                  mem_stall,
    output logic                  misalign,
    output logic                  bus_error,
    output logic [ADDR_WIDTH-1:0] m_awaddr,
    output logic [2:0]            m_awprot,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [31:0]           m_wdata,
    output logic [3:0]            m_wstrb,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [2:0]            m_arprot,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [31:0]           m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rvalid,
    output logic                  m_rready
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [2:0]            ld_type_q, ld_type_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  arvalid_q, arvalid_d;
    logic [31:0]           read_data_q, read_data_d;
    logic                  misalign_q, misalign_d;
    logic                  bus_error_q, bus_error_d;

    logic [31:0] lane_wdata;
    logic [3:0]  lane_wstrb;
    logic [31:0] lane_ld_data;
    logic        mis;

    lsu_lane_align #(
        .ALIGN_CHECK(ALIGN_CHECK)
    ) u_lane (
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr_lo   (result[1:0]),
        .store_type(store_type),
        .load_type (load_type),
        .store_data(op2_data),
        .ld_addr_lo(addr_q[1:0]),
        .ld_type   (ld_type_q),
        .rdata     (m_rdata),
        .wdata     (lane_wdata),
        .wstrb     (lane_wstrb),
        .ld_data   (lane_ld_data),
        .misalign  (mis)
    );

    // Next-state logic: accept an access in IDLE, walk the AXI handshakes, then one DONE cycle
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        ld_type_d   = ld_type_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        read_data_d = read_data_q;
        misalign_d  = 1'b0;
        bus_error_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mis) begin
                    misalign_d = 1'b1;
                end else if (mem_write) begin
                    state_d   = ST_WR_REQ;
                    addr_d    = result[ADDR_WIDTH-1:0];
                    wdata_d   = lane_wdata;
                    wstrb_d   = lane_wstrb;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                end else if (mem_read) begin
                    state_d   = ST_RD_REQ;
                    addr_d    = result[ADDR_WIDTH-1:0];
                    ld_type_d = load_type;
                    arvalid_d = 1'b1;
                end
            end
            ST_WR_REQ: begin
                awvalid_d = awvalid_q && !m_awready;
                wvalid_d  = wvalid_q && !m_wready;
                state_d   = (!awvalid_d && !wvalid_d) ? ST_WR_RESP : ST_WR_REQ;
            end
            ST_WR_RESP: begin
                state_d     = m_bvalid ? ST_DONE : ST_WR_RESP;
                bus_error_d = m_bvalid && resp_err(m_bresp);
            end
            ST_RD_REQ: begin
                arvalid_d = !m_arready;
                state_d   = m_arready ? ST_RD_RESP : ST_RD_REQ;
            end
            ST_RD_RESP: begin
                if (m_rvalid) begin
                    state_d     = ST_DONE;
                    read_data_d = resp_err(m_rresp) ? 32'h0 : lane_ld_data;
                    bus_error_d = resp_err(m_rresp);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset drops every valid immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            ld_type_q   <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            read_data_q <= '0;
            misalign_q  <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            ld_type_q   <= ld_type_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            read_data_q <= read_data_d;
            misalign_q  <= misalign_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign mem_stall = (state_q == ST_IDLE && (mem_read || mem_write) && !mis) ||
                       (state_q inside {ST_WR_REQ, ST_WR_RESP, ST_RD_REQ, ST_RD_RESP});

    assign calculated_result = result;
    assign read_data         = read_data_q;
    assign misalign          = misalign_q;
    assign bus_error         = bus_error_q;
    assign m_awaddr          = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign m_araddr          = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign m_awprot          = AXI_PROT;
    assign m_arprot          = AXI_PROT;
    assign m_awvalid         = awvalid_q;
    assign m_wvalid          = wvalid_q;
    assign m_arvalid         = arvalid_q;
    assign m_wdata           = wdata_q;
    assign m_wstrb           = wstrb_q;
    assign m_bready          = state_q == ST_WR_RESP;
    assign m_rready          = state_q == ST_RD_RESP;

endmodule

// File: tb/tb_mem_stage_axi.sv
// tb_mem_stage_axi: randomized scoreboard bench with a delay-programmable AXI4-Lite slave
module tb_mem_stage_axi;

    typedef struct {
        int          aw, w, b, ar, r;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } slv_t;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rd;
        logic        berr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] result, op2_data;
    logic        mem_read, mem_write;
    logic [1:0]  store_type;
    logic [2:0]  load_type;
    logic [31:0] read_data, calculated_result;
    logic        mem_stall, misalign, bus_error;
    logic [31:0] m_awaddr, m_araddr, m_wdata, m_rdata;
    logic [2:0]  m_awprot, m_arprot;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    slv_t slave_q[$];

    always #5 clk = ~clk;

    mem_stage_axi dut (
        .clk(clk), .rst(rst), .result(result), .op2_data(op2_data),
        .mem_read(mem_read), .mem_write(mem_write), .store_type(store_type), .load_type(load_type),
        .read_data(read_data), .calculated_result(calculated_result), .mem_stall(mem_stall),
        .misalign(misalign), .bus_error(bus_error),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outcome of one access, derived from access size and byte lanes
    function automatic exp_t model(input bit wr, input logic [1:0] st, input logic [2:0] lt,
                                   input logic [31:0] a, input logic [31:0] d, input slv_t s);
        exp_t        e;
        int          sz, lane;
        logic [31:0] v, m;
        lane   = int'(a % 4);
        sz     = wr ? (st == 2'd0 ? 1 : st == 2'd1 ? 2 : 4) : (lt[1:0] == 2'd0 ? 1 : lt[1:0] == 2'd1 ? 2 : 4);
        e.kind = (a % sz != 0) ? 2 : (wr ? 0 : 1);
        e.addr = a & ~32'h3;
        e.berr = s.resp != 2'b00;
        e.wdata = '0;
        for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = d[8*(i % sz) +: 8];
        e.wstrb = 4'(((1 << sz) - 1) << lane);
        v = s.rdata >> (8 * lane);
        m = (sz == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * sz)) - 32'h1;
        v = v & m;
        if (!lt[2] && sz < 4 && v[8*sz-1]) v = v | ~m;
        e.rd = e.berr ? 32'h0 : v;
        return e;
    endfunction

    task automatic do_op(input bit wr, input logic [1:0] st, input logic [2:0] lt,
                         input logic [31:0] a, input logic [31:0] d, input slv_t s);
        exp_t e;
        int   n, want;
        e    = model(wr, st, lt, a, d, s);
        want = e.kind == 2 ? 0 : e.kind == 0 ? 3 + (s.aw > s.w ? s.aw : s.w) + s.b : 3 + s.ar + s.r;
        sb.push_back(e);
        if (e.kind != 2) slave_q.push_back(s);
        result     = a;
        op2_data   = d;
        store_type = st;
        load_type  = lt;
        mem_write  = wr;
        mem_read   = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        n = 0;
        @(negedge clk);
        check("calc_result", calculated_result, a);
        while (mem_stall && n < 300) begin
            n++;
            @(negedge clk);
        end
        check("stall_cycles", n, want);
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        result    = $urandom;
        op2_data  = $urandom;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Slave: readies/responses appear a programmed number of cycles after the request is seen
    initial begin
        slv_t cur;
        bit   busy, aw_got, w_got, ar_got, phase;
        bit   aw_hs, w_hs, b_hs, ar_hs, r_hs;
        int   cnt, rc;
        busy = 0; aw_got = 0; w_got = 0; ar_got = 0; phase = 0; cnt = 0; rc = 0;
        cur = '{0, 0, 0, 0, 0, 32'h0, 2'b00};
        {m_awready, m_wready, m_bvalid, m_arready, m_rvalid} = '0;
        m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0;
        forever begin
            @(negedge clk);
            aw_hs = m_awvalid && m_awready;
            w_hs  = m_wvalid && m_wready;
            b_hs  = m_bvalid && m_bready;
            ar_hs = m_arvalid && m_arready;
            r_hs  = m_rvalid && m_rready;
            @(posedge clk);
            #1;
            if (!rst) begin
                busy = 0;
                {m_awready, m_wready, m_bvalid, m_arready, m_rvalid} = '0;
                continue;
            end
            if (busy) begin
                cnt++;
                if (phase) rc++;
                aw_got |= aw_hs;
                w_got  |= w_hs;
                ar_got |= ar_hs;
                phase   = (aw_got && w_got) || ar_got;
                if (b_hs || r_hs) busy = 0;
            end
            if (!busy && (m_awvalid || m_arvalid)) begin
                if (slave_q.size() == 0) check("slave_queue_size", 32'(slave_q.size()), 1);
                else begin
                    cur = slave_q.pop_front();
                    busy = 1; cnt = 0; rc = 0; aw_got = 0; w_got = 0; ar_got = 0; phase = 0;
                end
            end
            m_awready = busy && m_awvalid && !aw_got && cnt >= cur.aw;
            m_wready  = busy && m_wvalid && !w_got && cnt >= cur.w;
            m_bvalid  = busy && aw_got && w_got && rc >= cur.b;
            m_arready = busy && m_arvalid && !ar_got && cnt >= cur.ar;
            m_rvalid  = busy && ar_got && rc >= cur.r;
            m_bresp   = m_bvalid ? cur.resp : 2'b00;
            m_rresp   = m_rvalid ? cur.resp : 2'b00;
            m_rdata   = m_rvalid ? cur.rdata : $urandom;
        end
    end

    // Monitor: compares every handshake, DONE cycle and pulse against the scoreboard
    initial begin
        exp_t        e;
        bit          done_pend;
        int          done_kind;
        logic [31:0] rd_model;
        done_pend = 0; done_kind = 0; rd_model = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                done_pend = 0;
                rd_model  = '0;
                continue;
            end
            if (done_pend) begin
                done_pend = 0;
                if (sb.size() == 0) check("done_unexpected", 32'(sb.size()), 1);
                else begin
                    e = sb.pop_front();
                    check("done_kind", done_kind, e.kind);
                    if (e.kind == 1) rd_model = e.rd;
                    check("bus_error", bus_error, e.berr);
                    check("done_stall", mem_stall, 0);
                end
            end else check("stray_bus_error", bus_error, 0);
            check("read_data", read_data, rd_model);
            if (misalign) begin
                if (sb.size() == 0) check("misalign_unexpected", misalign, 0);
                else begin
                    e = sb.pop_front();
                    check("misalign_kind", e.kind, 2);
                end
            end
            if (m_awvalid && m_awready) begin
                if (sb.size() == 0) check("aw_unexpected", m_awvalid, 0);
                else begin
                    check("aw_kind", sb[0].kind, 0);
                    check("awaddr", m_awaddr, sb[0].addr);
                    check("awprot", m_awprot, 0);
                end
            end
            if (m_wvalid && m_wready && sb.size() != 0) begin
                check("wdata", m_wdata, sb[0].wdata);
                check("wstrb", m_wstrb, sb[0].wstrb);
            end
            if (m_arvalid && m_arready) begin
                if (sb.size() == 0) check("ar_unexpected", m_arvalid, 0);
                else begin
                    check("ar_kind", sb[0].kind, 1);
                    check("araddr", m_araddr, sb[0].addr);
                    check("arprot", m_arprot, 0);
                end
            end
            if (m_bvalid && m_bready) begin done_pend = 1; done_kind = 0; end
            if (m_rvalid && m_rready) begin done_pend = 1; done_kind = 1; end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        slv_t        z, s;
        logic [2:0]  lt_tab [5];
        logic [31:0] a;
        logic [1:0]  st;
        logic [2:0]  lt;
        bit          wr;
        int          sz;
        lt_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        z = '{0, 0, 0, 0, 0, 32'h0, 2'b00};
        rst = 1'b0; result = '0; op2_data = '0; mem_read = 0; mem_write = 0;
        store_type = '0; load_type = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awvalid", m_awvalid, 0);
        check("rst_wvalid", m_wvalid, 0);
        check("rst_arvalid", m_arvalid, 0);
        check("rst_bready", m_bready, 0);
        check("rst_rready", m_rready, 0);
        check("rst_read_data", read_data, 0);
        check("rst_misalign", misalign, 0);
        check("rst_bus_error", bus_error, 0);
        check("rst_stall", mem_stall, 0);
        check("rst_awaddr", m_awaddr, 0);
        check("rst_wdata", m_wdata, 0);
        check("rst_wstrb", m_wstrb, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_op(1, 2'b10, 3'b010, 32'h100, 32'hDEADBEEF, z);
        do_op(1, 2'b00, 3'b000, 32'h103, 32'h000000A5, z);
        s = z; s.rdata = 32'h80F07F11;
        do_op(0, 2'b00, 3'b000, 32'h102, 32'h0, s);
        do_op(0, 2'b00, 3'b100, 32'h102, 32'h0, s);
        do_op(0, 2'b00, 3'b001, 32'h102, 32'h0, s);
        s = z; s.aw = 2; s.w = 5;
        do_op(1, 2'b01, 3'b000, 32'h206, 32'h1234ABCD, s);
        s = z; s.r = 4; s.rdata = 32'hCAFEF00D;
        do_op(0, 2'b00, 3'b010, 32'h104, 32'h0, s);
        do_op(0, 2'b00, 3'b010, 32'h101, 32'h0, z);
        s = z; s.resp = 2'b10; s.rdata = 32'h55555555;
        do_op(0, 2'b00, 3'b010, 32'h200, 32'h0, s);
        s = z; s.resp = 2'b11;
        do_op(1, 2'b10, 3'b000, 32'h300, 32'h11223344, s);
        s = z; s.rdata = 32'h12345678;
        do_op(0, 2'b00, 3'b010, 32'h300, 32'h0, s);
        s = z; s.aw = 8; s.w = 8;
        slave_q.push_back(s);
        result = 32'h40; op2_data = 32'h9; store_type = 2'b10; mem_write = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_awvalid", m_awvalid, 1);
        rst = 1'b0; mem_write = 1'b0;
        #1;
        check("mid_rst_awvalid", m_awvalid, 0);
        check("mid_rst_wvalid", m_wvalid, 0);
        check("mid_rst_read_data", read_data, 0);
        check("mid_rst_stall", mem_stall, 0);
        repeat (2) @(posedge clk);
        slave_q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_op(1, 2'b10, 3'b000, 32'h40, 32'h77, z);
        for (int k = 0; k < 150; k++) begin
            wr = 1'($urandom_range(0, 1));
            st = 2'($urandom_range(0, 2));
            lt = lt_tab[$urandom_range(0, 4)];
            sz = wr ? (st == 2'd0 ? 1 : st == 2'd1 ? 2 : 4) : (lt[1:0] == 2'd0 ? 1 : lt[1:0] == 2'd1 ? 2 : 4);
            a = $urandom;
            if ($urandom_range(0, 4) != 0) a = a & ~32'(sz - 1);
            s.aw = $urandom_range(0, 3); s.w = $urandom_range(0, 3); s.b = $urandom_range(0, 3);
            s.ar = $urandom_range(0, 3); s.r = $urandom_range(0, 3);
            s.rdata = $urandom;
            s.resp = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            do_op(wr, st, lt, a, $urandom, s);
        end
        repeat (5) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 0);
        check("slave_q_drained", 32'(slave_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
